// File: rtl/x_input_conditioner.sv
// Button/switch conditioner: 2-flop synchroniser, Gray-coded debounce FSM and rise/fall strobes.
// Defining GLITCH_CNT_EN adds an 8-bit saturating count of rejected glitches on port glitch_cnt.
module x_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int CNT_W           = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       x,
  output logic       x_rise,
  output logic       x_fall,
`ifdef GLITCH_CNT_EN
  output logic [7:0] glitch_cnt,
`endif
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_RISE_WAIT = 2'b01,
    S_HIGH      = 2'b11,
    S_FALL_WAIT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           st;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  assign state = st;

  // Synchroniser stage: only sync2 is allowed to reach the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Debounce stage: x only moves after the new level survives a full wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= S_LOW;
      cnt    <= '0;
      x      <= 1'b0;
      x_rise <= 1'b0;
      x_fall <= 1'b0;
    end else begin
      x_rise <= 1'b0;
      x_fall <= 1'b0;
      case (st)
        S_LOW: begin
          if (sync2) begin
            st  <= S_RISE_WAIT;
            cnt <= '0;
          end
        end
        S_RISE_WAIT: begin
          if (!sync2) begin
            st  <= S_LOW;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            st     <= S_HIGH;
            x      <= 1'b1;
            x_rise <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (!sync2) begin
            st  <= S_FALL_WAIT;
            cnt <= '0;
          end
        end
        S_FALL_WAIT: begin
          if (sync2) begin
            st  <= S_HIGH;
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            st     <= S_LOW;
            x      <= 1'b0;
            x_fall <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          st  <= S_LOW;
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef GLITCH_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic glitch;
  assign glitch = ((st == S_RISE_WAIT) && !sync2) || ((st == S_FALL_WAIT) && sync2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_cnt <= 8'h00;
    else if (glitch) glitch_cnt <= sat_inc8(glitch_cnt);
  end
`endif

endmodule
